// File: rtl/cfg_delay_line.sv
// Complex-sample delay line with flush-time programmable depth, fill tracking and stall.
// Optional build macro CFG_DELAY_LINE_DATA_GATE_EN zeroes the data outputs while valid_out is low.
module cfg_delay_line #(
    parameter int DATA_WIDTH = 12,
    parameter int MAX_DEPTH  = 16,
    localparam int DW        = $clog2(MAX_DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         flush,
    input  logic [DW-1:0]                depth,
    input  logic signed [DATA_WIDTH-1:0] in_data_r,
    input  logic signed [DATA_WIDTH-1:0] in_data_i,
    input  logic                         valid_in,
    output logic signed [DATA_WIDTH-1:0] out_data_r,
    output logic signed [DATA_WIDTH-1:0] out_data_i,
    output logic                         valid_out,
    output logic                         primed,
    output logic [DW-1:0]                cur_depth
);

    localparam logic [DW-1:0] MAX_D = DW'(MAX_DEPTH);

    logic signed [DATA_WIDTH-1:0] r_data_r [MAX_DEPTH];
    logic signed [DATA_WIDTH-1:0] r_data_i [MAX_DEPTH];
    logic [MAX_DEPTH-1:0]         r_valid;
    logic [DW-1:0]                r_cur_depth;
    logic [DW-1:0]                r_fill_left;

    logic [DW-1:0]                w_depth_clamped;
    logic [DW-1:0]                w_out_idx;
    logic signed [DATA_WIDTH-1:0] w_sel_r;
    logic signed [DATA_WIDTH-1:0] w_sel_i;
    logic                         w_sel_v;

    always_comb begin
        w_depth_clamped = depth;
        if (depth == '0) begin
            w_depth_clamped = DW'(1);
        end else if (depth > MAX_D) begin
            w_depth_clamped = MAX_D;
        end
    end

    assign w_out_idx = r_cur_depth - DW'(1);

    always_comb begin
        w_sel_r = '0;
        w_sel_i = '0;
        w_sel_v = 1'b0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (w_out_idx == DW'(i)) begin
                w_sel_r = r_data_r[i];
                w_sel_i = r_data_i[i];
                w_sel_v = r_valid[i];
            end
        end
    end

    // Fill tracking is a down-counter loaded with the depth; primed is its terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_DEPTH; i++) begin
                r_data_r[i] <= '0;
                r_data_i[i] <= '0;
            end
            r_valid     <= '0;
            r_cur_depth <= MAX_D;
            r_fill_left <= MAX_D;
        end else if (flush) begin
            r_valid     <= '0;
            r_cur_depth <= w_depth_clamped;
            r_fill_left <= w_depth_clamped;
        end else if (!stall) begin
            r_data_r[0] <= in_data_r;
            r_data_i[0] <= in_data_i;
            r_valid[0]  <= valid_in;
            for (int i = 1; i < MAX_DEPTH; i++) begin
                r_data_r[i] <= r_data_r[i-1];
                r_data_i[i] <= r_data_i[i-1];
                r_valid[i]  <= r_valid[i-1];
            end
            if (r_fill_left != '0) begin
                r_fill_left <= r_fill_left - DW'(1);
            end
        end
    end

    assign valid_out = w_sel_v;
    assign primed    = (r_fill_left == '0);
    assign cur_depth = r_cur_depth;

`ifdef CFG_DELAY_LINE_DATA_GATE_EN
    assign out_data_r = w_sel_v ? w_sel_r : '0;
    assign out_data_i = w_sel_v ? w_sel_i : '0;
`else
    assign out_data_r = w_sel_r;
    assign out_data_i = w_sel_i;
`endif

endmodule

// File: tb/tb_cfg_delay_line.sv
// Directed bench for cfg_delay_line (DATA_WIDTH=12, MAX_DEPTH=16); sample n is driven as n - n*i.
// Stale-data expectations follow CFG_DELAY_LINE_DATA_GATE_EN when the bench is built with it.
module tb_cfg_delay_line;

    localparam int DATA_WIDTH = 12;
    localparam int MAX_DEPTH  = 16;
    localparam int DW         = $clog2(MAX_DEPTH + 1);

    logic                         clk;
    logic                         rst;
    logic                         stall;
    logic                         flush;
    logic [DW-1:0]                depth;
    logic signed [DATA_WIDTH-1:0] in_data_r;
    logic signed [DATA_WIDTH-1:0] in_data_i;
    logic                         valid_in;
    logic signed [DATA_WIDTH-1:0] out_data_r;
    logic signed [DATA_WIDTH-1:0] out_data_i;
    logic                         valid_out;
    logic                         primed;
    logic [DW-1:0]                cur_depth;

    int n_vec = 0;
    int n_err = 0;

    cfg_delay_line #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_DEPTH  (MAX_DEPTH)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .depth      (depth),
        .in_data_r  (in_data_r),
        .in_data_i  (in_data_i),
        .valid_in   (valid_in),
        .out_data_r (out_data_r),
        .out_data_i (out_data_i),
        .valid_out  (valid_out),
        .primed     (primed),
        .cur_depth  (cur_depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge with the given inputs; outputs are sampled 1 ns after the edge.
    task automatic cyc(input logic r, input logic f, input logic s, input logic v,
                       input int n, input int d);
        rst       = r;
        flush     = f;
        stall     = s;
        valid_in  = v;
        in_data_r = DATA_WIDTH'(n);
        in_data_i = DATA_WIDTH'(-n);
        depth     = DW'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input int n, input logic p);
        chk({tag, ".valid"}, 32'(valid_out), 32'(v));
        chk({tag, ".primed"}, 32'(primed), 32'(p));
        if (v) begin
            chk({tag, ".re"}, out_data_r, n);
            chk({tag, ".im"}, out_data_i, -n);
        end
    endtask

    // Raw stage contents while valid_out is low: zero in the gated build.
    task automatic chk_stale(input string tag, input int n);
`ifdef CFG_DELAY_LINE_DATA_GATE_EN
        chk({tag, ".re"}, out_data_r, 0);
        chk({tag, ".im"}, out_data_i, 0);
`else
        chk({tag, ".re"}, out_data_r, n);
        chk({tag, ".im"}, out_data_i, -n);
`endif
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0; valid_in = 1'b0;
        in_data_r = '0; in_data_i = '0; depth = '0;

        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst.re", out_data_r, 0);
        chk("rst.im", out_data_i, 0);
        chk("rst.valid", 32'(valid_out), 0);
        chk("rst.primed", 32'(primed), 0);
        chk("rst.depth", 32'(cur_depth), 16);

        // depth 4, continuous valid stream
        cyc(0, 1, 0, 0, 0, 4);
        chk("fl4.depth", 32'(cur_depth), 4);
        chk_out("fl4", 1'b0, 0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            cyc(0, 0, 0, 1, k, 0);
            chk_out($sformatf("d4.k%0d", k), k >= 4, k - 3, k >= 4);
        end

        // three stalled edges: input 99 ignored, outputs frozen on sample 7
        for (int s = 0; s < 3; s++) begin
            cyc(0, 0, 1, 1, 99, 0);
            chk_out($sformatf("stall%0d", s), 1'b1, 7, 1'b1);
        end
        for (int k = 11; k <= 14; k++) begin
            cyc(0, 0, 0, 1, k, 0);
            chk_out($sformatf("d4.k%0d", k), 1'b1, k - 3, 1'b1);
        end

        // depth 0 clamps to 1; stage 0 still holds sample 14
        cyc(0, 1, 0, 1, 50, 0);
        chk("fl0.depth", 32'(cur_depth), 1);
        chk_out("fl0", 1'b0, 0, 1'b0);
        chk_stale("fl0.stale", 14);
        cyc(0, 0, 0, 1, 20, 0);
        chk_out("d1.a", 1'b1, 20, 1'b1);
        cyc(0, 0, 0, 1, 21, 0);
        chk_out("d1.b", 1'b1, 21, 1'b1);
        cyc(0, 0, 0, 0, 22, 0);
        chk_out("d1.bubble", 1'b0, 0, 1'b1);
        chk_stale("d1.bubble", 22);

        // depth 31 clamps to 16; stage 15 holds the sample of advance 2 since reset
        cyc(0, 1, 0, 0, 0, 31);
        chk("fl31.depth", 32'(cur_depth), 16);
        chk_out("fl31", 1'b0, 0, 1'b0);
        chk_stale("fl31.stale", 2);
        for (int k = 1; k <= 16; k++) begin
            cyc(0, 0, 0, 1, 200 + k, 0);
            chk_out($sformatf("d16.k%0d", k), k == 16, 201, k == 16);
        end

        // back-to-back flushes
        cyc(0, 1, 0, 0, 0, 8);
        chk("bb1.depth", 32'(cur_depth), 8);
        chk("bb1.primed", 32'(primed), 0);
        cyc(0, 1, 0, 0, 0, 3);
        chk("bb2.depth", 32'(cur_depth), 3);
        chk("bb2.primed", 32'(primed), 0);
        cyc(0, 1, 0, 0, 0, 8);
        chk("bb3.depth", 32'(cur_depth), 8);
        chk("bb3.primed", 32'(primed), 0);
        for (int k = 1; k <= 10; k++) begin
            cyc(0, 0, 0, 1, 300 + k, 0);
            chk_out($sformatf("d8.k%0d", k), k >= 8, k - 7 + 300, k >= 8);
        end

        // flush together with valid_in and stall: sample 999 must never emerge
        cyc(0, 1, 1, 1, 999, 8);
        chk("fls.depth", 32'(cur_depth), 8);
        chk_out("fls", 1'b0, 0, 1'b0);
        chk_stale("fls.stale", 303);
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 0, 0, 0, 0, 0);
            chk_out($sformatf("fls.bub%0d", k), 1'b0, 0, k == 8);
        end
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 0, 0, 1, 500 + k, 0);
            chk_out($sformatf("fls.k%0d", k), k == 8, 501, 1'b1);
        end

        // reset beats flush mid-stream
        cyc(1, 1, 0, 1, 77, 2);
        chk("rstfl.re", out_data_r, 0);
        chk("rstfl.im", out_data_i, 0);
        chk("rstfl.valid", 32'(valid_out), 0);
        chk("rstfl.primed", 32'(primed), 0);
        chk("rstfl.depth", 32'(cur_depth), 16);

        // full occupancy straight out of reset
        for (int k = 1; k <= 17; k++) begin
            cyc(0, 0, 0, 1, 600 + k, 0);
            chk_out($sformatf("full.k%0d", k), k >= 16, k - 15 + 600, k >= 16);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
